dma_bus_switch: RTL

Bus ownership switch between the T80 CPU and the DMA engine. It turns the DMA engine's `busrq_n` into a CPU bus request and waits for the CPU's bus acknowledge. It then inserts guard cycles with all strobes inactive, grants the shared memory/I/O bus to the DMA engine, and hands the bus back cleanly when the DMA engine releases it. It sits directly downstream of the DMA engine: it consumes `dma_a`, `dma_dout` and the `dma_*_n` strobes, and returns `busak_n` and read data.

---
 rtl/dma_bus_switch_if.sv | 46 ++++
 rtl/dma_bus_switch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dma_bus_switch_if.sv
// Signal bundle between the DMA engine, the T80 CPU and the shared memory/I/O bus.
// The switch uses the slave modport; the environment driving it uses master.
interface dma_bus_switch_if;
  logic        dma_busrq_n;
  logic        dma_busak_n;
  logic [15:0] dma_a;
  logic [7:0]  dma_dout;
  logic        dma_mreq_n;
  logic        dma_iorq_n;
  logic        dma_rd_n;
  logic        dma_wr_n;
  logic [7:0]  dma_din;
  logic        cpu_busrq_n;
  logic        cpu_busak_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_mreq_n;
  logic        cpu_iorq_n;
  logic        cpu_rd_n;
  logic        cpu_wr_n;
  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_mreq_n;
  logic        bus_iorq_n;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic [7:0]  bus_din;
  logic        bus_dma;
  logic        bus_err;

  modport slave (
    input  dma_busrq_n, dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
    input  cpu_busak_n, cpu_a, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
    input  bus_din,
    output dma_busak_n, dma_din, cpu_busrq_n,
    output bus_a, bus_dout, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n, bus_dma, bus_err
  );

  modport master (
    output dma_busrq_n, dma_a, dma_dout, dma_mreq_n, dma_iorq_n, dma_rd_n, dma_wr_n,
    output cpu_busak_n, cpu_a, cpu_dout, cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n,
    output bus_din,
    input  dma_busak_n, dma_din, cpu_busrq_n,
    input  bus_a, bus_dout, bus_mreq_n, bus_iorq_n, bus_rd_n, bus_wr_n, bus_dma, bus_err
  );
endinterface

// File: rtl/dma_bus_switch.sv
// Hands the shared bus between the T80 and the DMA engine, with guard cycles of
// idle strobes at every ownership change.
//
// state      | meaning
// CPU_OWNS   | CPU drives the bus, no request pending
// WAIT_ACK   | bus requested from the CPU, waiting for its acknowledge
// SETTLE     | CPU off the bus, DMA address muxed, strobes held idle
// DMA_OWNS   | DMA engine granted and driving the bus
// DRAIN      | grant withdrawn, waiting for the last DMA cycle to finish
// RELEASE    | DMA done, strobes idle before returning the bus to the CPU
module dma_bus_switch #(
  parameter int unsigned GUARD_CYCLES = 1
) (
  input logic           clk,
  input logic           rst_n,
  dma_bus_switch_if.slave bif
);

  localparam bit        G_ZERO = (GUARD_CYCLES == 0);
  localparam logic [3:0] G_LOAD = G_ZERO ? 4'd0 : 4'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_CPU_OWNS,
    S_WAIT_ACK,
    S_SETTLE,
    S_DMA_OWNS,
    S_DRAIN,
    S_RELEASE
  } state_t;

  state_t     r_state;
  logic [3:0] r_gcnt;
  logic       r_cpu_busrq_n;
  logic       r_dma_busak_n;
  logic       r_bus_err;
  logic       r_hold;

  logic       w_dma_idle;
  logic       w_ack_lost;
  logic       w_bus_dma;
  logic       w_pass_dma;
  logic       w_force_idle;
  logic [3:0] w_strobes;

  assign w_dma_idle = bif.dma_mreq_n & bif.dma_iorq_n & bif.dma_rd_n & bif.dma_wr_n;
  assign w_ack_lost = bif.cpu_busak_n &
                      ((r_state == S_SETTLE) || (r_state == S_DMA_OWNS) || (r_state == S_DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_CPU_OWNS;
      r_gcnt        <= 4'd0;
      r_cpu_busrq_n <= 1'b1;
      r_dma_busak_n <= 1'b1;
      r_bus_err     <= 1'b0;
      r_hold        <= 1'b0;
    end else if (w_ack_lost) begin
      // CPU took the bus back under us: drop the grant and re-request.
      r_bus_err     <= 1'b1;
      r_dma_busak_n <= 1'b1;
      r_hold        <= 1'b1;
      r_state       <= S_WAIT_ACK;
    end else begin
      case (r_state)
        S_CPU_OWNS: begin
          if (!bif.dma_busrq_n) begin
            r_cpu_busrq_n <= 1'b0;
            r_state       <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (bif.dma_busrq_n) begin
            r_cpu_busrq_n <= 1'b1;
            r_hold        <= 1'b0;
            r_state       <= S_CPU_OWNS;
          end else if (!bif.cpu_busak_n) begin
            r_hold <= 1'b0;
            if (G_ZERO) begin
              r_dma_busak_n <= 1'b0;
              r_state       <= S_DMA_OWNS;
            end else begin
              r_gcnt  <= G_LOAD;
              r_state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (r_gcnt == 4'd0) begin
            r_dma_busak_n <= 1'b0;
            r_state       <= S_DMA_OWNS;
          end else begin
            r_gcnt <= r_gcnt - 4'd1;
          end
        end
        S_DMA_OWNS, S_DRAIN: begin
          if ((r_state == S_DMA_OWNS) && bif.dma_busrq_n) begin
            r_dma_busak_n <= 1'b1;
          end
          if ((r_state == S_DRAIN) || bif.dma_busrq_n) begin
            if (!w_dma_idle) begin
              r_state <= S_DRAIN;
            end else if (G_ZERO) begin
              r_cpu_busrq_n <= 1'b1;
              r_state       <= S_CPU_OWNS;
            end else begin
              r_gcnt  <= G_LOAD;
              r_state <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (r_gcnt == 4'd0) begin
            r_cpu_busrq_n <= 1'b1;
            r_state       <= S_CPU_OWNS;
          end else begin
            r_gcnt <= r_gcnt - 4'd1;
          end
        end
        default: r_state <= S_CPU_OWNS;
      endcase
    end
  end

  always_comb begin
    w_bus_dma    = 1'b0;
    w_pass_dma   = 1'b0;
    w_force_idle = 1'b0;
    case (r_state)
      S_SETTLE, S_RELEASE: begin
        w_bus_dma    = 1'b1;
        w_force_idle = 1'b1;
      end
      S_DMA_OWNS, S_DRAIN: begin
        w_bus_dma  = 1'b1;
        w_pass_dma = 1'b1;
      end
      S_WAIT_ACK: w_force_idle = r_hold;
      default: ;
    endcase

    if (w_force_idle) begin
      w_strobes = 4'hF;
    end else if (w_pass_dma) begin
      w_strobes = {bif.dma_mreq_n, bif.dma_iorq_n, bif.dma_rd_n, bif.dma_wr_n};
    end else begin
      w_strobes = {bif.cpu_mreq_n, bif.cpu_iorq_n, bif.cpu_rd_n, bif.cpu_wr_n};
    end
  end

  assign bif.bus_a       = w_bus_dma ? bif.dma_a    : bif.cpu_a;
  assign bif.bus_dout    = w_bus_dma ? bif.dma_dout : bif.cpu_dout;
  assign bif.bus_mreq_n  = w_strobes[3];
  assign bif.bus_iorq_n  = w_strobes[2];
  assign bif.bus_rd_n    = w_strobes[1];
  assign bif.bus_wr_n    = w_strobes[0];
  assign bif.bus_dma     = w_bus_dma;
  assign bif.bus_err     = r_bus_err;
  assign bif.dma_din     = bif.bus_din;
  assign bif.dma_busak_n = r_dma_busak_n;
  assign bif.cpu_busrq_n = r_cpu_busrq_n;

endmodule
